// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared size codes, FSM states and size decode for the CPU-to-memory bridge
package cpu_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;
    localparam logic [2:0] F3_XX = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ0,
        ST_WAIT0,
        ST_REQ1,
        ST_WAIT1,
        ST_RESP
    } state_t;

    // Access size in bytes; the unsigned variants share the low two bits with the signed ones.
    function automatic logic [3:0] size_bytes(input logic [2:0] sel);
        case (sel[1:0])
            2'b00:   size_bytes = 4'd1;
            2'b01:   size_bytes = 4'd2;
            2'b10:   size_bytes = 4'd4;
            default: size_bytes = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane placement of store data and enables, and load realignment/extension
module mem_lane_align
    import cpu_mem_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [2:0]               i_sel,
    input  logic [$clog2(DW/8)-1:0]  i_offset,
    input  logic [DW-1:0]            i_wdata,
    input  logic [DW-1:0]            i_lo,
    input  logic [DW-1:0]            i_hi,
    output logic [DW-1:0]            o_data0,
    output logic [DW-1:0]            o_data1,
    output logic [DW/8-1:0]          o_sel0,
    output logic [DW/8-1:0]          o_sel1,
    output logic                     o_split,
    output logic [DW-1:0]            o_rdata
);

    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);
    localparam int MW = 2 * NB;

    logic [3:0]      w_size;
    logic [OW+2:0]   w_bits;
    logic [MW-1:0]   w_mask;
    logic [2*DW-1:0] w_wide;
    logic [DW-1:0]   w_shift;
    logic [DW-1:0]   w_ext;

    assign w_size  = size_bytes(i_sel);
    assign w_bits  = {i_offset, 3'b000};
    assign w_mask  = MW'((16'd1 << w_size) - 16'd1) << i_offset;
    assign o_sel0  = w_mask[NB-1:0];
    assign o_sel1  = w_mask[MW-1:NB];
    assign o_split = (5'(i_offset) + 5'(w_size)) > 5'(NB);

    assign w_wide  = {{DW{1'b0}}, i_wdata} << w_bits;
    assign o_data0 = w_wide[DW-1:0];
    assign o_data1 = w_wide[2*DW-1:DW];

    // The two captured beats form one 2*DW window; the access starts at byte "offset".
    assign w_shift = DW'({i_hi, i_lo} >> w_bits);

    always_comb begin
        w_ext = w_shift;
        case (i_sel)
            F3_B:    w_ext = DW'({{56{w_shift[7]}},  w_shift[7:0]});
            F3_H:    w_ext = DW'({{48{w_shift[15]}}, w_shift[15:0]});
            F3_W:    w_ext = DW'({{32{w_shift[31]}}, w_shift[31:0]});
            F3_BU:   w_ext = DW'({56'b0, w_shift[7:0]});
            F3_HU:   w_ext = DW'({48'b0, w_shift[15:0]});
            F3_WU:   w_ext = DW'({32'b0, w_shift[31:0]});
            default: w_ext = w_shift;
        endcase
    end

    assign o_rdata = w_ext;

endmodule

// File: rtl/cpu_mem_bridge.sv
// rtl/cpu_mem_bridge.sv - CPU load/store to pipelined Wishbone master with misaligned-access splitting
module cpu_mem_bridge
    import cpu_mem_pkg::*;
#(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_wb_stb,
    input  logic            i_wb_we,
    input  logic [AW-1:0]   i_wb_addr,
    input  logic [DW-1:0]   i_wb_data,
    input  logic [2:0]      i_sel,
    output logic            o_wb_stall,
    output logic            o_wb_ack,
    output logic            o_wb_err,
    output logic [DW-1:0]   o_wb_data,
    output logic            o_mem_cyc,
    output logic            o_mem_stb,
    output logic            o_mem_we,
    output logic [AW-1:0]   o_mem_addr,
    output logic [DW-1:0]   o_mem_data,
    output logic [DW/8-1:0] o_mem_sel,
    input  logic            i_mem_ack,
    input  logic            i_mem_stall,
    input  logic            i_mem_err,
    input  logic [DW-1:0]   i_mem_data
);

    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);

    state_t        r_state;
    state_t        w_next;
    logic          r_rdy;
    logic          r_we;
    logic          r_err;
    logic [2:0]    r_sel;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_lo;
    logic [DW-1:0] r_hi;

    logic          w_accept;
    logic          w_bad;
    logic          w_misalign;
    logic [3:0]    w_in_size;
    logic [AW-1:0] w_base;
    logic [AW-1:0] w_base1;
    logic [DW-1:0] w_data0;
    logic [DW-1:0] w_data1;
    logic [DW-1:0] w_rdata;
    logic [NB-1:0] w_sel0;
    logic [NB-1:0] w_sel1;
    logic          w_split;

    mem_lane_align #(.DW(DW)) u_align (
        .i_sel    (r_sel),
        .i_offset (r_addr[OW-1:0]),
        .i_wdata  (r_wdata),
        .i_lo     (r_lo),
        .i_hi     (r_hi),
        .o_data0  (w_data0),
        .o_data1  (w_data1),
        .o_sel0   (w_sel0),
        .o_sel1   (w_sel1),
        .o_split  (w_split),
        .o_rdata  (w_rdata)
    );

    // r_rdy holds off acceptance until reset has been released across one full edge.
    assign w_accept   = (r_state == ST_IDLE) && r_rdy && i_wb_stb;
    assign w_in_size  = size_bytes(i_sel);
    assign w_misalign = (i_wb_addr[3:0] & (w_in_size - 4'd1)) != 4'd0;
    assign w_bad      = (i_sel == F3_XX)
                      || ((DW == 32) && ((i_sel == F3_D) || (i_sel == F3_WU)))
                      || (!MISALIGN_EN && w_misalign);
    assign w_base     = {r_addr[AW-1:OW], {OW{1'b0}}};
    assign w_base1    = w_base + AW'(NB);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        o_wb_stall = 1'b1;
        o_wb_ack   = 1'b0;
        o_wb_err   = 1'b0;
        o_wb_data  = '0;
        o_mem_cyc  = 1'b0;
        o_mem_stb  = 1'b0;
        o_mem_we   = 1'b0;
        o_mem_addr = '0;
        o_mem_data = '0;
        o_mem_sel  = '0;
        case (r_state)
            ST_IDLE: begin
                o_wb_stall = !r_rdy;
                if (w_accept) begin
                    w_next = w_bad ? ST_RESP : ST_REQ0;
                end
            end
            ST_REQ0, ST_WAIT0: begin
                o_mem_cyc  = 1'b1;
                o_mem_stb  = (r_state == ST_REQ0);
                o_mem_we   = r_we;
                o_mem_addr = w_base;
                o_mem_data = w_data0;
                o_mem_sel  = w_sel0;
                if (r_state == ST_REQ0) begin
                    if (!i_mem_stall) w_next = ST_WAIT0;
                end else if (i_mem_err) begin
                    w_next = ST_RESP;
                end else if (i_mem_ack) begin
                    w_next = w_split ? ST_REQ1 : ST_RESP;
                end
            end
            ST_REQ1, ST_WAIT1: begin
                o_mem_cyc  = 1'b1;
                o_mem_stb  = (r_state == ST_REQ1);
                o_mem_we   = r_we;
                o_mem_addr = w_base1;
                o_mem_data = w_data1;
                o_mem_sel  = w_sel1;
                if (r_state == ST_REQ1) begin
                    if (!i_mem_stall) w_next = ST_WAIT1;
                end else if (i_mem_err || i_mem_ack) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                o_wb_ack  = !r_err;
                o_wb_err  = r_err;
                o_wb_data = (!r_err && !r_we) ? w_rdata : '0;
                w_next    = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rdy   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_sel   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
        end else begin
            r_rdy <= 1'b1;
            if (w_accept) begin
                r_we    <= i_wb_we;
                r_err   <= w_bad;
                r_sel   <= i_sel;
                r_addr  <= i_wb_addr;
                r_wdata <= i_wb_data;
                r_lo    <= '0;
                r_hi    <= '0;
            end else if (((r_state == ST_WAIT0) || (r_state == ST_WAIT1)) && i_mem_err) begin
                r_err <= 1'b1;
            end else if ((r_state == ST_WAIT0) && i_mem_ack) begin
                r_lo <= i_mem_data;
            end else if ((r_state == ST_WAIT1) && i_mem_ack) begin
                r_hi <= i_mem_data;
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// tb/tb_cpu_mem_bridge.sv - directed self-checking bench for cpu_mem_bridge in three configurations
module tb_cpu_mem_bridge;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  stb;
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [2:0]  sel;
    logic        mack, mstall, merr;
    logic [63:0] mdata;

    logic        a_stall, a_ack, a_err, a_cyc, a_stb, a_we;
    logic [31:0] a_wbd, a_addr, a_md;
    logic [3:0]  a_sel;
    logic        b_stall, b_ack, b_err, b_cyc, b_stb, b_we;
    logic [31:0] b_wbd, b_addr, b_md;
    logic [3:0]  b_sel;
    logic        c_stall, c_ack, c_err, c_cyc, c_stb, c_we;
    logic [63:0] c_wbd, c_md;
    logic [31:0] c_addr;
    logic [7:0]  c_sel;

    cpu_mem_bridge #(.DW(32), .AW(32), .MISALIGN_EN(1'b1)) u_a (
        .i_clk(clk), .i_reset(rst_n), .i_wb_stb(stb[0]), .i_wb_we(we), .i_wb_addr(addr),
        .i_wb_data(wdata[31:0]), .i_sel(sel), .o_wb_stall(a_stall), .o_wb_ack(a_ack),
        .o_wb_err(a_err), .o_wb_data(a_wbd), .o_mem_cyc(a_cyc), .o_mem_stb(a_stb),
        .o_mem_we(a_we), .o_mem_addr(a_addr), .o_mem_data(a_md), .o_mem_sel(a_sel),
        .i_mem_ack(mack), .i_mem_stall(mstall), .i_mem_err(merr), .i_mem_data(mdata[31:0]));

    cpu_mem_bridge #(.DW(32), .AW(32), .MISALIGN_EN(1'b0)) u_b (
        .i_clk(clk), .i_reset(rst_n), .i_wb_stb(stb[1]), .i_wb_we(we), .i_wb_addr(addr),
        .i_wb_data(wdata[31:0]), .i_sel(sel), .o_wb_stall(b_stall), .o_wb_ack(b_ack),
        .o_wb_err(b_err), .o_wb_data(b_wbd), .o_mem_cyc(b_cyc), .o_mem_stb(b_stb),
        .o_mem_we(b_we), .o_mem_addr(b_addr), .o_mem_data(b_md), .o_mem_sel(b_sel),
        .i_mem_ack(mack), .i_mem_stall(mstall), .i_mem_err(merr), .i_mem_data(mdata[31:0]));

    cpu_mem_bridge #(.DW(64), .AW(32), .MISALIGN_EN(1'b1)) u_c (
        .i_clk(clk), .i_reset(rst_n), .i_wb_stb(stb[2]), .i_wb_we(we), .i_wb_addr(addr),
        .i_wb_data(wdata), .i_sel(sel), .o_wb_stall(c_stall), .o_wb_ack(c_ack),
        .o_wb_err(c_err), .o_wb_data(c_wbd), .o_mem_cyc(c_cyc), .o_mem_stb(c_stb),
        .o_mem_we(c_we), .o_mem_addr(c_addr), .o_mem_data(c_md), .o_mem_sel(c_sel),
        .i_mem_ack(mack), .i_mem_stall(mstall), .i_mem_err(merr), .i_mem_data(mdata));

    int          dsel;
    logic        m_stall, m_ack, m_err, m_cyc, m_stb, m_we;
    logic [63:0] m_wbd, m_md;
    logic [31:0] m_addr;
    logic [7:0]  m_sel;

    always_comb begin
        case (dsel)
            1: begin
                m_stall = b_stall; m_ack = b_ack; m_err = b_err; m_cyc = b_cyc; m_stb = b_stb;
                m_we = b_we; m_wbd = {32'b0, b_wbd}; m_md = {32'b0, b_md}; m_addr = b_addr;
                m_sel = {4'b0, b_sel};
            end
            2: begin
                m_stall = c_stall; m_ack = c_ack; m_err = c_err; m_cyc = c_cyc; m_stb = c_stb;
                m_we = c_we; m_wbd = c_wbd; m_md = c_md; m_addr = c_addr; m_sel = c_sel;
            end
            default: begin
                m_stall = a_stall; m_ack = a_ack; m_err = a_err; m_cyc = a_cyc; m_stb = a_stb;
                m_we = a_we; m_wbd = {32'b0, a_wbd}; m_md = {32'b0, a_md}; m_addr = a_addr;
                m_sel = {4'b0, a_sel};
            end
        endcase
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int          r_nbeat, r_stb_first, r_stb_last, r_ack_k, r_err_k, r_nack, r_nerr;
    logic        r_cycseen;
    logic [63:0] r_data;
    logic [31:0] bt_addr [2];
    logic [7:0]  bt_sel  [2];
    logic [63:0] bt_data [2];
    logic [63:0] rd      [2];

    // One CPU request; the bench acts as a slave that stalls beat0 stall_n cycles and acks the cycle after acceptance.
    task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [2:0] s,
                        input logic [63:0] wd, input int stall_n, input bit err0, input bit rst_wait1);
        int left;
        bit rst_done;
        left = stall_n;
        rst_done = 1'b0;
        r_nbeat = 0; r_stb_first = -1; r_stb_last = -1; r_ack_k = -1; r_err_k = -1;
        r_nack = 0; r_nerr = 0; r_data = '0; r_cycseen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bt_addr[i] = '0; bt_sel[i] = '0; bt_data[i] = '0;
        end
        @(negedge clk);
        dsel = d; we = w; addr = a; sel = s; wdata = wd;
        stb = 3'(1 << d);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            stb = 3'b000; mack = 1'b0; merr = 1'b0; mstall = 1'b0;
            if (m_cyc) r_cycseen = 1'b1;
            if (m_ack) begin r_nack++; r_ack_k = k; r_data = m_wbd; end
            if (m_err) begin r_nerr++; r_err_k = k; r_data = m_wbd; end
            if (m_stb) begin
                if (r_stb_first < 0) r_stb_first = k;
                r_stb_last = k;
                if (left > 0) begin
                    mstall = 1'b1;
                    left--;
                end else if (r_nbeat < 2) begin
                    bt_addr[r_nbeat] = m_addr;
                    bt_sel[r_nbeat]  = m_sel;
                    bt_data[r_nbeat] = m_md;
                    r_nbeat++;
                end
            end else if (m_cyc) begin
                if (rst_wait1 && (r_nbeat == 2) && !rst_done) begin
                    rst_n = 1'b0;
                    rst_done = 1'b1;
                    #1;
                    chk("rst_mid_cyc",   64'(m_cyc),   64'd0);
                    chk("rst_mid_stb",   64'(m_stb),   64'd0);
                    chk("rst_mid_stall", 64'(m_stall), 64'd1);
                    chk("rst_mid_addr",  64'(m_addr),  64'd0);
                    chk("rst_mid_sel",   64'(m_sel),   64'd0);
                end else if (err0 && (r_nbeat == 1)) begin
                    merr = 1'b1;
                end else if (r_nbeat > 0) begin
                    mack = 1'b1;
                    mdata = rd[r_nbeat-1];
                end
            end
        end
        if (rst_done) begin
            @(negedge clk);
            rst_n = 1'b1;
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0; stb = '0; we = 1'b0; addr = '0; wdata = '0; sel = '0;
        mack = 1'b0; mstall = 1'b0; merr = 1'b0; mdata = '0; dsel = 0;
        rd[0] = '0; rd[1] = '0;
        repeat (3) @(negedge clk);
        chk("rst_stall", 64'(a_stall), 64'd1);
        chk("rst_cyc",   64'(a_cyc),   64'd0);
        chk("rst_ack",   64'(a_ack),   64'd0);
        chk("rst_wbd",   c_wbd,        64'd0);
        chk("rst_addr",  64'(c_addr),  64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_stall_first", 64'(a_stall), 64'd1);
        @(negedge clk);
        chk("rel_stall_after", 64'(a_stall), 64'd0);

        rd[0] = 64'h8000_00FF;
        xact(0, 1'b0, 32'h100, 3'b010, 64'h0, 0, 1'b0, 1'b0);
        chk("lw_nbeat", 64'(r_nbeat), 64'd1);
        chk("lw_addr",  64'(bt_addr[0]), 64'h100);
        chk("lw_sel",   64'(bt_sel[0]), 64'hF);
        chk("lw_stbk",  64'(r_stb_first), 64'd1);
        chk("lw_ackk",  64'(r_ack_k), 64'd3);
        chk("lw_nack",  64'(r_nack), 64'd1);
        chk("lw_data",  r_data, 64'h8000_00FF);

        rd[0] = 64'h1234_5678; rd[1] = 64'h9ABC_DE80;
        xact(0, 1'b0, 32'h103, 3'b001, 64'h0, 0, 1'b0, 1'b0);
        chk("lh_nbeat", 64'(r_nbeat), 64'd2);
        chk("lh_addr0", 64'(bt_addr[0]), 64'h100);
        chk("lh_sel0",  64'(bt_sel[0]), 64'h8);
        chk("lh_addr1", 64'(bt_addr[1]), 64'h104);
        chk("lh_sel1",  64'(bt_sel[1]), 64'h1);
        chk("lh_ackk",  64'(r_ack_k), 64'd5);
        chk("lh_data",  r_data, 64'hFFFF_8012);
        xact(0, 1'b0, 32'h103, 3'b101, 64'h0, 0, 1'b0, 1'b0);
        chk("lhu_data", r_data, 64'h0000_8012);

        rd[0] = 64'h0000_8000;
        xact(0, 1'b0, 32'h201, 3'b000, 64'h0, 0, 1'b0, 1'b0);
        chk("lb_data", r_data, 64'hFFFF_FF80);
        xact(0, 1'b0, 32'h201, 3'b100, 64'h0, 0, 1'b0, 1'b0);
        chk("lbu_data", r_data, 64'h0000_0080);

        xact(0, 1'b1, 32'h102, 3'b010, 64'hAABB_CCDD, 0, 1'b0, 1'b0);
        chk("sw_data0", bt_data[0], 64'hCCDD_0000);
        chk("sw_sel0",  64'(bt_sel[0]), 64'hC);
        chk("sw_data1", bt_data[1], 64'h0000_AABB);
        chk("sw_sel1",  64'(bt_sel[1]), 64'h3);
        chk("sw_ackk",  64'(r_ack_k), 64'd5);
        chk("sw_wbd",   r_data, 64'd0);

        xact(1, 1'b1, 32'h001, 3'b001, 64'h1234, 0, 1'b0, 1'b0);
        chk("sh_mis_cyc",  64'(r_cycseen), 64'd0);
        chk("sh_mis_errk", 64'(r_err_k), 64'd1);
        chk("sh_mis_nack", 64'(r_nack), 64'd0);
        xact(1, 1'b0, 32'h008, 3'b011, 64'h0, 0, 1'b0, 1'b0);
        chk("ld32_errk", 64'(r_err_k), 64'd1);
        xact(0, 1'b0, 32'h100, 3'b111, 64'h0, 0, 1'b0, 1'b0);
        chk("sel7_errk", 64'(r_err_k), 64'd1);
        chk("sel7_cyc",  64'(r_cycseen), 64'd0);

        rd[0] = 64'h5555_5555; rd[1] = 64'h6666_6666;
        xact(0, 1'b0, 32'h102, 3'b010, 64'h0, 0, 1'b1, 1'b0);
        chk("err0_nbeat", 64'(r_nbeat), 64'd1);
        chk("err0_nerr",  64'(r_nerr), 64'd1);
        chk("err0_nack",  64'(r_nack), 64'd0);
        chk("err0_wbd",   r_data, 64'd0);

        rd[0] = 64'h0000_0042;
        xact(0, 1'b0, 32'h100, 3'b010, 64'h0, 5, 1'b0, 1'b0);
        chk("stall_first", 64'(r_stb_first), 64'd1);
        chk("stall_last",  64'(r_stb_last), 64'd6);
        chk("stall_ackk",  64'(r_ack_k), 64'd8);
        chk("stall_data",  r_data, 64'h42);

        rd[0] = 64'h1122_3344_5566_7788; rd[1] = 64'h0000_0000_0000_F0E0;
        xact(2, 1'b0, 32'hFFFF_FFFE, 3'b010, 64'h0, 0, 1'b0, 1'b0);
        chk("d64_addr0", 64'(bt_addr[0]), 64'hFFFF_FFF8);
        chk("d64_sel0",  64'(bt_sel[0]), 64'hC0);
        chk("d64_addr1", 64'(bt_addr[1]), 64'h0);
        chk("d64_sel1",  64'(bt_sel[1]), 64'h03);
        chk("d64_data",  r_data, 64'hFFFF_FFFF_F0E0_1122);
        xact(2, 1'b0, 32'hFFFF_FFFE, 3'b010, 64'h0, 0, 1'b0, 1'b1);
        chk("d64_rst_nack", 64'(r_nack), 64'd0);
        chk("d64_rst_nerr", 64'(r_nerr), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_mem_bridge.md
CPU_MEM_BRIDGE -- requirements
Module: cpu_mem_bridge

Interface
REQ-001 Parameter DW, default 32, data width in bits; legal values 32 or 64.
REQ-002 Parameter AW, default 32, byte-address width.
REQ-003 Parameter MISALIGN_EN, default 1, where 1 splits misaligned accesses and 0 reports them as errors.
REQ-004 i_clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 i_reset  in  1  asynchronous, active-low reset.
REQ-006 i_wb_stb  in  1  CPU request strobe.
REQ-007 i_wb_we  in  1  CPU store (1) / load (0).
REQ-008 i_wb_addr  in  AW  CPU byte address.
REQ-009 i_wb_data  in  DW  CPU store data, right-justified.
REQ-010 i_sel  in  3  RISC-V funct3 size code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-011 o_wb_stall  out  1  high when the block is not accepting a request.
REQ-012 o_wb_ack  out  1  one-cycle completion pulse.
REQ-013 o_wb_err  out  1  one-cycle error-completion pulse.
REQ-014 o_wb_data  out  DW  load result, right-justified and extended.
REQ-015 o_mem_cyc, o_mem_stb, o_mem_we  out  1 each  pipelined Wishbone B4 master controls.
REQ-016 o_mem_addr  out  AW  memory address, aligned to DW/8 bytes.
REQ-017 o_mem_data  out  DW  lane-positioned store data.
REQ-018 o_mem_sel  out  DW/8  byte enables.
REQ-019 i_mem_ack, i_mem_stall, i_mem_err  in  1 each  slave handshake inputs.
REQ-020 i_mem_data  in  DW  slave read data.

Function
REQ-021 States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- o_wb_stall=0 only in IDLE.
- i_wb_stb outside IDLE is ignored.
REQ-022 IDLE with i_wb_stb=1: latch we/addr/data/sel and go to REQ0; go to RESP with error if any of the following holds:
- sel is 111;
- sel is 011 or 110 with DW=32;
- the access is misaligned and MISALIGN_EN=0.
REQ-023 Size is 1/2/4/8 bytes, offset is addr mod DW/8, and the access is split when offset+size > DW/8; natural misalignment within one word does not split.
REQ-024 Beat signals:
- Beat0: addr = aligned addr; sel = size mask shifted left by offset, truncated to DW/8.
- Beat1: addr = aligned addr + DW/8, modulo 2^AW (wraps to 0); sel = the remaining high bytes.
REQ-025 Store data: {DW'b0, i_wb_data} is shifted left by 8*offset over 2*DW bits; beat0 carries the low DW bits and beat1 the high DW bits.
REQ-026 Bus signals in REQ0/REQ1 and WAIT0/WAIT1:
- REQn: o_mem_cyc=1, o_mem_stb=1; advance to WAITn in the first cycle with i_mem_stall=0.
- WAITn: o_mem_cyc=1, o_mem_stb=0.
REQ-027 WAIT0 with i_mem_ack: capture i_mem_data as lo, then go to REQ1 if split, else RESP; WAIT1 with i_mem_ack: capture hi, then go to RESP.
- o_mem_cyc drops in the cycle after the final ack.
REQ-028 i_mem_err in any WAIT state: abandon the access with no further beats and go to RESP with error; an ack and an err in the same cycle count as err.
REQ-029 RESP lasts one cycle, asserts exactly one of o_wb_ack / o_wb_err, then returns to IDLE.
- o_wb_data = ({hi,lo} >> 8*offset), truncated to size, sign-extended for B/H/W and zero-extended for BU/HU/WU.
- For stores and errors, o_wb_data = 0.
REQ-030 Latency, for request accepted at edge t with a slave that has zero stall and acks in the next cycle: o_mem_stb high during t+1, o_wb_ack high during t+3 unsplit or t+5 split.
REQ-031 The bus never has more than one outstanding beat; o_mem_stb is never asserted while waiting for an ack.

Reset
REQ-032 While i_reset=0:
- state=IDLE;
- all outputs 0 except o_wb_stall=1;
- latched registers cleared.
REQ-033 Reset asserted mid-transaction drops o_mem_cyc/o_mem_stb immediately (asynchronously), and no ack/err is issued for the aborted request.
REQ-034 The first request is accepted only on an edge where i_reset has been 1 for at least one prior edge.

Structure
REQ-035 Shared package cpu_mem_pkg holds:
- funct3 size-code localparams;
- the state enum;
- the size-decode function.
REQ-036 One combinational sub-module, mem_lane_align, performs store shift, sel generation, load shift and extension; the FSM and registers live in cpu_mem_bridge.

Verification
REQ-037 DW=32, LW at 0x100, i_mem_data=0x8000_00FF -> single beat with o_mem_sel=1111; o_wb_ack at t+3 with o_wb_data=0x8000_00FF.
REQ-038 DW=32, LH at 0x103, beat0 data 0x12xx_xxxx and beat1 data 0xxxxx_xx80 -> beats at 0x100 (sel 1000) and 0x104 (sel 0001); o_wb_data=0xFFFF_8012; LHU of the same gives 0x0000_8012.
REQ-039 DW=32, SW 0xAABBCCDD at 0x102 -> beat0 data 0xCCDD_xxxx with sel 1100; beat1 data 0xxxxx_AABB with sel 0011.
REQ-040 DW=32, MISALIGN_EN=0, SH at 0x001 -> no o_mem_cyc; o_wb_err at t+1. LD with DW=32 -> o_wb_err.
REQ-041 Split load whose beat0 returns i_mem_err -> no beat1, one o_wb_err pulse; an i_mem_stall held for 5 cycles delays o_mem_stb acceptance by exactly 5 cycles.
REQ-042 DW=64, LW at 0xFFFF_FFFE (AW=32) -> beat1 address 0x0000_0000; i_reset pulled low during WAIT1 -> all outputs cleared that cycle, and no ack is issued.
